// File: rtl/qerv_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : qerv_pc_seq
// Purpose  : Instruction sequencer for a bit/nibble-serial RISC-V core.
//            Fetches one instruction at a time, then runs one or two serial
//            passes of N cycles (W bits per cycle) over the datapath, and
//            decodes the running slice position for the execution units.
// Revision : 1.0  initial release
// ============================================================================
module qerv_pc_seq #(
    parameter int W = 4,        // datapath bits per cycle (1 or 4)
    parameter int N = 32 / W    // cycles per serial pass, derived from W
) (
    input  logic clk,
    input  logic i_rst,
    output logic o_ibus_cyc,
    input  logic i_ibus_ack,
    input  logic i_two_stage,
    output logic o_cnt_en,
    output logic o_pc_en,
    output logic o_cnt0,
    output logic o_cnt03,
    output logic o_cnt12to31,
    output logic o_cnt_done,
    output logic o_stage2
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_RUN1   = 3'd3,
        S_RUN2   = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            two_q;

    logic            w_run;
    logic            w_last;
    logic [6:0]      w_idx;

    // Sequencer: one instruction in flight, RUN2 always returns straight to FETCH.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            two_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_ibus_ack) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // The two-stage flag is captured here and held for the
                    // whole instruction, regardless of later input changes.
                    two_q   <= i_two_stage;
                    cnt_q   <= '0;
                    state_q <= i_two_stage ? S_RUN1 : S_RUN2;
                end
                S_RUN1: begin
                    if (w_last) begin
                        cnt_q   <= '0;
                        state_q <= S_RUN2;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_RUN2: begin
                    if (w_last) begin
                        cnt_q   <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign w_run  = (state_q == S_RUN1) || (state_q == S_RUN2);
    assign w_last = (cnt_q == C_LAST);

    // Lowest bit index covered by the current slice.
    assign w_idx  = 7'(cnt_q) * 7'(W);

    // All outputs are pure decodes of the state/counter flops.
    assign o_ibus_cyc  = (state_q == S_FETCH);
    assign o_cnt_en    = w_run;
    assign o_pc_en     = (state_q == S_RUN2);
    assign o_cnt0      = w_run && (cnt_q == '0);
    assign o_cnt03     = w_run && (w_idx < 7'd4);
    assign o_cnt12to31 = w_run && (w_idx >= 7'd12);
    assign o_cnt_done  = w_run && w_last;
    assign o_stage2    = (state_q == S_RUN2) && two_q;

endmodule
`default_nettype wire
